// File: rtl/wb_sel_pipe_if.sv
// Writeback-select bus: upstream result handshake with packed sources, downstream register-file handshake.
interface wb_sel_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/wb_sel_pipe.sv
// N-input writeback mux registered into a 2-entry skid buffer; 1-cycle latency, registered in_ready.
// Illegal selects produce data 0 with out_err; define WBSEL_ERRCNT_EN for a saturating illegal-select counter.
module wb_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  wb_sel_pipe_if.slave     bus,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_e;

  cnt_e             cnt_q, cnt_d;
  logic [WIDTH-1:0] h_dat_q, h_dat_d;
  logic [WIDTH-1:0] s_dat_q, s_dat_d;
  logic             h_err_q, h_err_d;
  logic             s_err_q, s_err_d;
  logic             in_rdy_q;

  logic [WIDTH-1:0] sel_dat;
  logic             sel_err;
  logic             push;
  logic             pop;

  // Full decode over legal indices; anything unmatched falls through to 0/err.
  always_comb begin
    sel_dat = '0;
    sel_err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_dat = bus.in_data[k*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

  assign push = bus.in_valid & in_rdy_q;
  assign pop  = (cnt_q != EMPTY) & bus.out_ready;

  always_comb begin
    cnt_d   = cnt_q;
    h_dat_d = h_dat_q;
    h_err_d = h_err_q;
    s_dat_d = s_dat_q;
    s_err_d = s_err_q;
    if (flush) begin
      cnt_d = EMPTY;
    end else begin
      case (cnt_q)
        EMPTY: begin
          if (push) begin
            cnt_d   = ONE;
            h_dat_d = sel_dat;
            h_err_d = sel_err;
          end
        end
        ONE: begin
          if (push && !pop) begin
            cnt_d   = FULL;
            s_dat_d = sel_dat;
            s_err_d = sel_err;
          end else if (push && pop) begin
            h_dat_d = sel_dat;
            h_err_d = sel_err;
          end else if (pop) begin
            cnt_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            cnt_d   = ONE;
            h_dat_d = s_dat_q;
            h_err_d = s_err_q;
          end
        end
        default: cnt_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= EMPTY;
      h_dat_q  <= '0;
      h_err_q  <= 1'b0;
      s_dat_q  <= '0;
      s_err_q  <= 1'b0;
      in_rdy_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      h_dat_q  <= h_dat_d;
      h_err_q  <= h_err_d;
      s_dat_q  <= s_dat_d;
      s_err_q  <= s_err_d;
      in_rdy_q <= (cnt_d != FULL);
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = (cnt_q != EMPTY);
  assign bus.out_data  = h_dat_q;
  assign bus.out_err   = h_err_q;

`ifdef WBSEL_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts every accepted illegal push, including one killed by a same-cycle flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (push && sel_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Bench for wb_sel_pipe: a 4-input and a 3-input instance share stimulus and are checked against a queue model.
module tb_wb_sel_pipe;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   in_sel;
  logic [127:0] in_data;
  logic [7:0]   err_cnt_a, err_cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  wb_sel_pipe_if #(.WIDTH(32), .NUM_IN(4)) ifa ();
  wb_sel_pipe_if #(.WIDTH(32), .NUM_IN(3)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_sel    = in_sel;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_sel    = in_sel;
  assign ifb.in_data   = in_data[95:0];
  assign ifb.out_ready = out_ready;

  wb_sel_pipe #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa.slave), .err_cnt(err_cnt_a));
  wb_sel_pipe #(.WIDTH(32), .NUM_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb.slave), .err_cnt(err_cnt_b));

  always #5 clk = ~clk;

  logic        d_vld [2];
  logic        d_rdy [2];
  logic        d_err [2];
  logic [31:0] d_dat [2];
  logic [7:0]  d_cnt [2];
  assign d_vld[0] = ifa.out_valid; assign d_vld[1] = ifb.out_valid;
  assign d_rdy[0] = ifa.in_ready;  assign d_rdy[1] = ifb.in_ready;
  assign d_err[0] = ifa.out_err;   assign d_err[1] = ifb.out_err;
  assign d_dat[0] = ifa.out_data;  assign d_dat[1] = ifb.out_data;
  assign d_cnt[0] = err_cnt_a;     assign d_cnt[1] = err_cnt_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance is a FIFO of {err,data} with capacity 2.
  int          m_cnt [2];
  logic [32:0] m_ent [2][2];
  logic [7:0]  m_ec  [2];
  logic        m_init = 1'b0;

  int          t_cnt, t_nin;
  logic [32:0] t_e0, t_e1, t_new;
  logic [7:0]  t_ec;
  logic        t_push, t_pop;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0;
        m_ec[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t_cnt  = m_cnt[i];
        t_e0   = m_ent[i][0];
        t_e1   = m_ent[i][1];
        t_ec   = m_ec[i];
        t_nin  = (i == 0) ? 4 : 3;
        t_new  = (int'(in_sel) < t_nin) ? {1'b0, in_data[int'(in_sel)*32 +: 32]} : {1'b1, 32'd0};
        t_push = in_valid && (t_cnt < 2);
        t_pop  = (t_cnt > 0) && out_ready;
`ifdef WBSEL_ERRCNT_EN
        if (t_push && t_new[32] && t_ec != 8'hFF) t_ec = t_ec + 8'd1;
`endif
        if (flush) begin
          t_cnt = 0;
        end else begin
          if (t_pop) begin
            t_e0  = t_e1;
            t_cnt = t_cnt - 1;
          end
          if (t_push) begin
            if (t_cnt == 0) t_e0 = t_new;
            else            t_e1 = t_new;
            t_cnt = t_cnt + 1;
          end
        end
        m_cnt[i]    <= t_cnt;
        m_ent[i][0] <= t_e0;
        m_ent[i][1] <= t_e1;
        m_ec[i]     <= t_ec;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_out_valid[%0d]", i), 64'(d_vld[i]), 64'(m_cnt[i] != 0));
        chk($sformatf("model_in_ready[%0d]", i),  64'(d_rdy[i]), 64'(m_cnt[i] != 2));
        chk($sformatf("model_err_cnt[%0d]", i),   64'(d_cnt[i]), 64'(m_ec[i]));
        if (m_cnt[i] != 0) begin
          chk($sformatf("model_out_data[%0d]", i), 64'(d_dat[i]), 64'(m_ent[i][0][31:0]));
          chk($sformatf("model_out_err[%0d]", i),  64'(d_err[i]), 64'(m_ent[i][0][32]));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sat;

  initial begin
`ifdef WBSEL_ERRCNT_EN
    exp_sat = 8'hFF;
`else
    exp_sat = 8'h00;
`endif
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = 2'd0;
    in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    tick; tick;
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_out_data",  64'(ifa.out_data),  64'd0);
    chk("rst_out_err",   64'(ifa.out_err),   64'd0);
    chk("rst_in_ready",  64'(ifa.in_ready),  64'd1);
    chk("rst_err_cnt",   64'(err_cnt_a),     64'd0);
    rst_n = 1'b1;
    tick;

    // Single push of source 2.
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("single_valid", 64'(ifa.out_valid), 64'd1);
    chk("single_data",  64'(ifa.out_data),  64'h3);
    chk("single_err",   64'(ifa.out_err),   64'd0);
    tick;
    chk("single_drain", 64'(ifa.out_valid), 64'd0);

    // Back-pressure fills the skid entry, then drains in order.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    tick;
    in_sel = 2'd3;
    tick;
    chk("bp_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("bp_hold",     64'(ifa.out_data), 64'h1);
    tick;
    chk("bp_stable",   64'(ifa.out_data), 64'h1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    chk("bp_second",   64'(ifa.out_data), 64'h4);
    chk("bp_ready",    64'(ifa.in_ready), 64'd1);
    tick;
    chk("bp_empty",    64'(ifa.out_valid), 64'd0);

    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_sel = 2'(k % 4);
      tick;
      chk("stream_valid", 64'(ifa.out_valid), 64'd1);
      chk("stream_data",  64'(ifa.out_data),  64'(k % 4 + 1));
    end
    in_valid = 1'b0;
    tick;

    // Flush of a full buffer with a pending input.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    tick;
    in_sel = 2'd2;
    tick;
    flush = 1'b1; in_sel = 2'd3;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", 64'(ifa.out_valid), 64'd0);
    chk("flush_full_ready", 64'(ifa.in_ready),  64'd1);
    out_ready = 1'b1;
    tick;
    chk("flush_full_gone", 64'(ifa.out_valid), 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    tick;
    flush = 1'b1; in_sel = 2'd3;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_push_valid", 64'(ifa.out_valid), 64'd0);
    chk("flush_push_ready", 64'(ifa.in_ready),  64'd1);
    tick;
    chk("flush_push_gone",  64'(ifa.out_valid), 64'd0);

    // Illegal select on the 3-input instance.
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    tick;
    chk("illegal_valid", 64'(ifb.out_valid), 64'd1);
    chk("illegal_data",  64'(ifb.out_data),  64'd0);
    chk("illegal_err",   64'(ifb.out_err),   64'd1);
    chk("legal_err_a",   64'(ifa.out_err),   64'd0);
    for (int k = 0; k < 300; k++) tick;
    chk("errcnt_sat",    64'(err_cnt_b), 64'(exp_sat));
    chk("errcnt_legal",  64'(err_cnt_a), 64'd0);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("errcnt_flush",  64'(err_cnt_b), 64'(exp_sat));

    // Reset in the middle of a full buffer.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    tick; tick;
    rst_n = 1'b0;
    tick;
    chk("midrst_valid",  64'(ifa.out_valid), 64'd0);
    chk("midrst_data",   64'(ifa.out_data),  64'd0);
    chk("midrst_err",    64'(ifb.out_err),   64'd0);
    chk("midrst_ready",  64'(ifa.in_ready),  64'd1);
    chk("midrst_errcnt", 64'(err_cnt_b),     64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_sel    = 2'($urandom % 4);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      flush     = ($urandom % 20) == 0;
      rst_n     = ($urandom % 250) != 0;
      tick;
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_sel_pipe.md
Name: wb_sel_pipe

Overview:
- Parametrised writeback-select stage for the RISC-V datapath. It replaces the fixed 4-input combinational writeback mux with an N-input, W-bit mux.
- The mux result is registered into a 2-entry skid buffer with valid/ready handshakes on both sides.
- It sits between the execute/memory stage (input sources PC+4, ALU, DMEM and others) and the register-file write port.
- Illegal selects are flagged, not latched, and a flush input kills queued results.

Parameters:
- WIDTH, 32, data width of every input and of the output.
- NUM_IN, 4, number of source inputs (≥2).
- SEL_W, $clog2(NUM_IN), select width (derived; min 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept (registered).
- in_sel  input  SEL_W  source index; legal when < NUM_IN.
- in_data  input  NUM_IN*WIDTH  packed sources; source k is bits [k*WIDTH +: WIDTH].
- out_valid  output  1  head entry valid.
- out_ready  input  1  register-file port accepts.
- out_data  output  WIDTH  selected data of head entry.
- out_err  output  1  head entry was captured with an illegal select.
- err_cnt  output  8  illegal-select counter (only with WBSEL_ERRCNT_EN; otherwise tied 0).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - count=0, out_valid=0, out_data=0, out_err=0, in_ready=1, err_cnt=0.
  - Reset dominates flush and all transfers.
- Mux (combinational, sampled at push):
  - Legal select: selected = in_data[in_sel*WIDTH +: WIDTH], err=0.
  - in_sel ≥ NUM_IN: selected = 0, err=1.
  - No latch is inferred for any select value.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: head register H (drives outputs) and skid register S, each holding {data, err}. State count ∈ {EMPTY=0, ONE=1, FULL=2}.
- Transitions (flush=0):
  - EMPTY, push → ONE; H ← selected.
  - ONE, push & !pop → FULL; S ← selected.
  - ONE, push & pop → ONE; H ← selected.
  - ONE, pop & !push → EMPTY.
  - FULL, pop → ONE; H ← S. No push is possible because in_ready=0.
  - No push and no pop → hold all state.
- in_ready is registered and equals (next count ≠ FULL).
- out_valid = (count ≠ EMPTY).
- Latency: a push in cycle t is visible on out_data/out_valid in cycle t+1.
- Throughput: 1 entry per cycle with out_ready held high.
- While out_valid=1 and out_ready=0, out_data and out_err remain stable.
- flush=1 at a rising edge:
  - count → EMPTY, out_valid → 0, in_ready → 1.
  - A same-cycle push is discarded and a same-cycle pop is void.
  - out_data is not cleared (don't-care while invalid). The verifier checks out_valid only.
- out_data and out_err hold their last value while out_valid=0.

Optional Feature:
- Macro WBSEL_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on every push with an illegal select.
  - Saturates at 8'hFF.
  - Cleared only by reset; flush does not clear it.
- Undefined:
  - err_cnt is driven constant 0 and no counter flops exist.
  - The out_err per-entry flag is still present in both builds.

Test Plan:
- Reset with NUM_IN=4, WIDTH=32, rst_n=0 for 2 cycles, then 1 → out_valid=0, out_data=0, out_err=0, in_ready=1, err_cnt=0.
- Inputs {4,3,2,1} (sources 3..0), in_sel=2, single push, out_ready=1 → next cycle out_valid=1, out_data=0x3, out_err=0; following cycle out_valid=0.
- Back-pressure test:
  - Stimulus: out_ready=0; push sel=0 (0x1), then push sel=3 (0x4); keep in_valid=1.
  - Expected: in_ready=0 after the second push and out_data holds 0x1.
  - Then out_ready=1: outputs 0x1 then 0x4 on consecutive cycles, in_ready returns 1, with no loss or duplication.
- Streaming with in_valid and out_ready high for 16 cycles, sel cycling 0..3 → out_data sequence 1,2,3,4 repeated, delayed one cycle, with out_valid continuously 1.
- Illegal select with NUM_IN=3 and in_sel=3 → out_data=0, out_err=1. With WBSEL_ERRCNT_EN, 300 illegal pushes give err_cnt=0xFF; without the macro, err_cnt=0.
- Flush and reset interactions:
  - FULL buffer, then flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the pushed value never appears.
  - rst_n=0 asserted mid-stream → all outputs return to reset values at the next edge.
